// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and special instruction words.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2,
    StHalt = 2'd3
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

endpackage

// File: rtl/if_instruction_memory.sv
// Instruction memory: one synchronous write port, one combinational read port, no reset.
module if_instruction_memory #(
  parameter int unsigned NB_INST   = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned NB_MADDR  = 8
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [NB_MADDR-1:0] i_waddr,
  input  logic [NB_INST-1:0]  i_wdata,
  input  logic [NB_MADDR-1:0] i_raddr,
  output logic [NB_INST-1:0]  o_rdata
);

  logic [NB_INST-1:0] mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: run/step/halt FSM, PC register, local instruction memory and the
// IF/ID output register feeding decode.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned       NB_ADDR   = 32,
  parameter int unsigned       NB_INST   = 32,
  parameter int unsigned       MEM_DEPTH = 256,
  parameter int unsigned       NB_MADDR  = 8,
  parameter logic [NB_INST-1:0] HALT_WORD = NB_INST'(HALT_WORD_DEFAULT)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_step_mode,
  input  logic                i_step,
  input  logic                i_clear,
  input  logic                i_stall,
  input  logic                i_pc_src,
  input  logic [NB_ADDR-1:0]  i_pc_target,
  input  logic                i_mem_we,
  input  logic [NB_MADDR-1:0] i_mem_addr,
  input  logic [NB_INST-1:0]  i_mem_data,
  output logic [NB_ADDR-1:0]  o_pc,
  output logic [NB_INST-1:0]  o_instruction,
  output logic                o_valid,
  output logic                o_halt,
  output logic [1:0]          o_state
);

  localparam logic [NB_INST-1:0] NOP = NB_INST'(NOP_WORD);

  fetch_state_e       state_q;
  logic [NB_ADDR-1:0] pc_q;
  logic [NB_ADDR-1:0] out_pc_q;
  logic [NB_INST-1:0] inst_q;
  logic               valid_q;

  logic [NB_INST-1:0] fetch_word;
  logic [NB_ADDR-1:0] pc_plus4;
  logic               fetch_en;

  // Program loading is only allowed while idle so a running program cannot be corrupted.
  if_instruction_memory #(
    .NB_INST  (NB_INST),
    .MEM_DEPTH(MEM_DEPTH),
    .NB_MADDR (NB_MADDR)
  ) u_imem (
    .i_clk  (i_clk),
    .i_we   (i_mem_we && (state_q == StIdle)),
    .i_waddr(i_mem_addr),
    .i_wdata(i_mem_data),
    .i_raddr(pc_q[NB_MADDR+1:2]),
    .o_rdata(fetch_word)
  );

  assign pc_plus4 = pc_q + NB_ADDR'(4);
  assign fetch_en = (state_q == StRun) || i_step;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      out_pc_q <= '0;
      inst_q   <= NOP;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pc_q    <= '0;
          inst_q  <= NOP;
          valid_q <= 1'b0;
          if (i_start) begin
            state_q <= i_step_mode ? StStep : StRun;
          end
        end
        StRun, StStep: begin
          if (i_clear) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            out_pc_q <= '0;
            inst_q   <= NOP;
            valid_q  <= 1'b0;
          end else if (i_pc_src) begin
            // Redirect flushes the slot being fetched, even if decode is stalling.
            pc_q    <= i_pc_target;
            inst_q  <= NOP;
            valid_q <= 1'b0;
          end else if (i_stall) begin
            // Hold PC and IF/ID register.
          end else if (fetch_en) begin
            inst_q   <= fetch_word;
            out_pc_q <= pc_plus4;
            valid_q  <= 1'b1;
            if (fetch_word == HALT_WORD) begin
              state_q <= StHalt;
            end else begin
              pc_q <= pc_plus4;
            end
          end else begin
            inst_q  <= NOP;
            valid_q <= 1'b0;
          end
        end
        StHalt: begin
          inst_q  <= NOP;
          valid_q <= 1'b0;
          if (i_clear) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            out_pc_q <= '0;
          end
        end
      endcase
    end
  end

  assign o_pc          = out_pc_q;
  assign o_instruction = inst_q;
  assign o_valid       = valid_q;
  assign o_halt        = (state_q == StHalt);
  assign o_state       = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        clear;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;
  logic        halt;
  logic [1:0]  state;

  int tests;
  int fails;

  if_fetch_stage dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_step_mode  (step_mode),
    .i_step       (step),
    .i_clear      (clear),
    .i_stall      (stall),
    .i_pc_src     (pc_src),
    .i_pc_target  (pc_target),
    .i_mem_we     (mem_we),
    .i_mem_addr   (mem_addr),
    .i_mem_data   (mem_data),
    .o_pc         (pc),
    .o_instruction(instruction),
    .o_valid      (valid),
    .o_halt       (halt),
    .o_state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot: o_pc, o_instruction, o_valid, o_halt, o_state.
  task automatic expect_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                            input logic e_valid, input logic e_halt, input logic [1:0] e_state);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".inst"}, instruction, e_inst);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    check({tag, ".halt"}, {31'd0, halt}, {31'd0, e_halt});
    check({tag, ".state"}, {30'd0, state}, {30'd0, e_state});
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    mem_we   = 1'b1;
    mem_addr = a;
    mem_data = d;
    tick();
    mem_we   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    stall     = 1'b0;
    pc_src    = 1'b0;
    pc_target = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;

    #2;
    expect_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();

    load(8'd0,   32'h2001_0005);
    load(8'd1,   32'h2002_0003);
    load(8'd2,   32'h0022_1820);
    load(8'd3,   32'hFFFF_FFFF);
    load(8'd16,  32'hCAFE_0010);
    load(8'd17,  32'hFFFF_FFFF);
    load(8'd255, 32'hBEEF_00FF);
    expect_out("idle_after_load", 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);

    // Free run to HALT.
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("run_entry", 32'h0, 32'h0, 1'b0, 1'b0, 2'd1);
    tick();
    expect_out("run_f0", 32'd4, 32'h2001_0005, 1'b1, 1'b0, 2'd1);
    tick();
    expect_out("run_f1", 32'd8, 32'h2002_0003, 1'b1, 1'b0, 2'd1);
    tick();
    expect_out("run_f2", 32'd12, 32'h0022_1820, 1'b1, 1'b0, 2'd1);
    tick();
    expect_out("run_halt_entry", 32'd16, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'd3);
    tick();
    expect_out("halt_bubble", 32'd16, 32'h0, 1'b0, 1'b1, 2'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("halt_ignores_start", 32'd16, 32'h0, 1'b0, 1'b1, 2'd3);
    do_clear();
    expect_out("clear_from_halt", 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);

    // Stall at pc=8, with an ignored memory write to mem[1] in RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    expect_out("pre_stall", 32'd8, 32'h2002_0003, 1'b1, 1'b0, 2'd1);
    stall    = 1'b1;
    mem_we   = 1'b1;
    mem_addr = 8'd1;
    mem_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall_hold", 32'd8, 32'h2002_0003, 1'b1, 1'b0, 2'd1);
    end
    stall  = 1'b0;
    mem_we = 1'b0;
    tick();
    expect_out("stall_resume", 32'd12, 32'h0022_1820, 1'b1, 1'b0, 2'd1);

    // Redirect together with stall: redirect wins.
    pc_src    = 1'b1;
    pc_target = 32'h40;
    stall     = 1'b1;
    tick();
    pc_src = 1'b0;
    stall  = 1'b0;
    expect_out("redirect_flush", 32'd12, 32'h0, 1'b0, 1'b0, 2'd1);
    tick();
    expect_out("redirect_fetch", 32'h44, 32'hCAFE_0010, 1'b1, 1'b0, 2'd1);
    tick();
    expect_out("redirect_halt", 32'h48, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'd3);
    do_clear();

    // mem[1] must be unchanged; then word-address and 32-bit PC wrap.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    expect_out("mem1_retained", 32'd8, 32'h2002_0003, 1'b1, 1'b0, 2'd1);
    pc_src    = 1'b1;
    pc_target = 32'h3FC;
    tick();
    pc_src = 1'b0;
    tick();
    expect_out("fetch_mem255", 32'h400, 32'hBEEF_00FF, 1'b1, 1'b0, 2'd1);
    tick();
    expect_out("wrap_mem0", 32'h404, 32'h2001_0005, 1'b1, 1'b0, 2'd1);
    pc_src    = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    tick();
    pc_src = 1'b0;
    tick();
    expect_out("pc_wrap32", 32'h0, 32'hBEEF_00FF, 1'b1, 1'b0, 2'd1);
    tick();
    expect_out("pc_wrap32_next", 32'h4, 32'h2001_0005, 1'b1, 1'b0, 2'd1);
    pc_src    = 1'b1;
    pc_target = 32'h42;
    tick();
    pc_src = 1'b0;
    tick();
    expect_out("unaligned_target", 32'h46, 32'hCAFE_0010, 1'b1, 1'b0, 2'd1);
    tick();
    expect_out("unaligned_halt", 32'h4A, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'd3);
    do_clear();

    // Single-step mode.
    start     = 1'b1;
    step_mode = 1'b1;
    tick();
    start     = 1'b0;
    step_mode = 1'b0;
    expect_out("step_entry", 32'h0, 32'h0, 1'b0, 1'b0, 2'd2);
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_out("step_f0", 32'd4, 32'h2001_0005, 1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("step_bubble0", 32'd4, 32'h0, 1'b0, 1'b0, 2'd2);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_out("step_f1", 32'd8, 32'h2002_0003, 1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("step_bubble1", 32'd8, 32'h0, 1'b0, 1'b0, 2'd2);
    end
    step  = 1'b1;
    stall = 1'b1;
    tick();
    step  = 1'b0;
    stall = 1'b0;
    expect_out("step_stalled", 32'd8, 32'h0, 1'b0, 1'b0, 2'd2);
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_out("step_f2", 32'd12, 32'h0022_1820, 1'b1, 1'b0, 2'd2);
    do_clear();
    expect_out("step_clear", 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset mid-run, memory retained afterwards.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    expect_out("pre_reset", 32'd8, 32'h2002_0003, 1'b1, 1'b0, 2'd1);
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    expect_out("post_reset_f0", 32'd4, 32'h2001_0005, 1'b1, 1'b0, 2'd1);
    tick();
    expect_out("post_reset_f1", 32'd8, 32'h2002_0003, 1'b1, 1'b0, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
